// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//  Shared types and constants for the game front-end (keyboard handling and
//  state controller).
//  Contents:
//   key_state_t     debounce FSM state encoding used by key_press_pulser
//   KEY_ENTER       USB HID usage code for Enter
//   KEY_SPACE       USB HID usage code for Space
//   KEY_NONE        HID "no key" code, never a legal watch target
//   NUM_KEY_BYTES   number of keycode bytes delivered by the USB PIO
//   key_byte()      extracts keycode byte i from the packed PIO word
// -----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_DEB   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_DEB = 2'd3
   } key_state_t;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam int unsigned NUM_KEY_BYTES = 4;

   // Byte i of the PIO word sits at keycode[8i+7:8i].
   function automatic logic [7:0] key_byte(input logic [8*NUM_KEY_BYTES-1:0] keycode,
                                           input int unsigned idx);
      return keycode[8*idx +: 8];
   endfunction

endpackage : game_pkg

// File: rtl/keycode_match.sv
// -----------------------------------------------------------------------------
// keycode_match
//  Combinational detector: reports whether the configured key appears in any
//  of the four keycode slots delivered by the USB keyboard PIO. A key that
//  shows up in several slots still yields a single hit.
//  Parameters:
//   KEY_CODE    HID usage code to look for (must not be KEY_NONE)
//  Ports:
//   keycode_i   in  32  four packed HID keycodes, slot i = keycode_i[8i+7:8i]
//   hit_o       out 1   1 when any slot equals KEY_CODE
// -----------------------------------------------------------------------------
module keycode_match
   import game_pkg::*;
#(
   parameter logic [7:0] KEY_CODE = KEY_ENTER
) (
   input  logic [8*NUM_KEY_BYTES-1:0] keycode_i,
   output logic                       hit_o
);

   logic [NUM_KEY_BYTES-1:0] slot_hit;

   always_comb begin
      // NOTE: every signal written in always_comb gets a default before any
      // conditional code, so no path can leave it unassigned and infer a latch.
      slot_hit = '0;
      for (int unsigned i = 0; i < NUM_KEY_BYTES; i++) begin
         slot_hit[i] = (key_byte(keycode_i, i) == KEY_CODE);
      end
   end

   assign hit_o = |slot_hit;

endmodule : keycode_match

// File: rtl/key_press_pulser.sv
// -----------------------------------------------------------------------------
// key_press_pulser
//  Upstream stage of the game state controller. Watches the keycode bytes from
//  the USB keyboard PIO for one configured key, debounces both press and
//  release, and emits a one-cycle pulse per debounced press. key_pulse feeds
//  the state controller's nextStateSig input.
//  Parameters:
//   KEY_CODE         HID usage code to watch (KEY_NONE is not a legal value)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed for press and release (>=1)
//   CNT_W            width of press_count, which wraps modulo 2**CNT_W
//  Ports:
//   Clk          in   1      system clock, everything on posedge
//   Reset        in   1      synchronous active-high reset, overrides all
//   keycode      in   32     four HID keycodes, same clock domain
//   en           in   1      gates pulse and count; FSM keeps tracking when 0
//   key_level    out  1      debounced key state (1 = held)
//   key_pulse    out  1      one cycle high per debounced press while en=1
//   press_count  out  CNT_W  pulses emitted since reset
//  Timing: a match first present in cycle 0 gives key_pulse/key_level in cycle
//  DEBOUNCE_CYCLES+2; key_level falls DEBOUNCE_CYCLES+2 cycles after the match
//  goes away. All outputs are registers.
// -----------------------------------------------------------------------------
module key_press_pulser
   import game_pkg::*;
#(
   parameter logic [7:0]  KEY_CODE        = KEY_ENTER,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [8*NUM_KEY_BYTES-1:0] keycode,
   input  logic                       en,
   output logic                       key_level,
   output logic                       key_pulse,
   output logic [CNT_W-1:0]           press_count
);

   // The debounce counter only ever reaches DEBOUNCE_CYCLES-1.
   localparam int unsigned     DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // Key detection
   // ---------------------------------------------------------------------------
   logic hit;

   keycode_match #(
      .KEY_CODE (KEY_CODE)
   ) u_match (
      .keycode_i (keycode),
      .hit_o     (hit)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic             hit_q;
   key_state_t       state_q,  state_d;
   logic [DEB_W-1:0] cnt_q,    cnt_d;
   logic             level_q,  level_d;
   logic             pulse_q,  pulse_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             press_done;

   // ---------------------------------------------------------------------------
   // Next-state logic. The FSM only looks at the registered hit, so the
   // comparator tree never sits in front of the state decode.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         RELEASED: begin
            if (hit_q) begin
               state_d = PRESS_DEB;
               cnt_d   = '0;
            end
         end

         PRESS_DEB: begin
            if (!hit_q) begin
               state_d = RELEASED;             // press bounce: drop it
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + DEB_W'(1);
            end
         end

         PRESSED: begin
            if (!hit_q) begin
               state_d = RELEASE_DEB;
               cnt_d   = '0;
            end
         end

         RELEASE_DEB: begin
            if (hit_q) begin
               state_d = PRESSED;              // release bounce: still held
            end else if (cnt_q == DEB_LAST) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q + DEB_W'(1);
            end
         end

         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output next values. A pulse is only generated on the PRESS_DEB -> PRESSED
   // edge; returning to PRESSED from RELEASE_DEB is the same held press. A
   // press completed while en=0 is simply lost.
   // ---------------------------------------------------------------------------
   always_comb begin
      press_done = (state_q == PRESS_DEB) && (state_d == PRESSED);
      pulse_d    = press_done && en;
      level_d    = (state_d == PRESSED) || (state_d == RELEASE_DEB);
      count_d    = pulse_d ? count_q + CNT_W'(1) : count_q;
   end

   // ---------------------------------------------------------------------------
   // Registers. Reset is synchronous and overrides everything.
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (Reset) begin
         hit_q   <= 1'b0;
         state_q <= RELEASED;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         count_q <= '0;
      end else begin
         hit_q   <= hit;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         count_q <= count_d;
      end
   end

   assign key_level   = level_q;
   assign key_pulse   = pulse_q;
   assign press_count = count_q;

endmodule : key_press_pulser

// File: tb/tb_key_press_pulser.sv
// -----------------------------------------------------------------------------
// tb_key_press_pulser
//  Directed bench for key_press_pulser with KEY_CODE=8'h28, DEBOUNCE_CYCLES=4,
//  CNT_W=8. Inputs change 1 time unit after a rising edge; that cycle is
//  cycle 0 of a window, and outputs are read 1 time unit after each
//  following edge (cycle 1, 2, ...).
// -----------------------------------------------------------------------------
module tb_key_press_pulser;

   localparam int unsigned DEB  = 4;
   localparam int unsigned CNTW = 8;
   localparam int          NEVER = 9999;

   logic            Clk = 1'b0;
   logic            Reset;
   logic [31:0]     keycode;
   logic            en;
   logic            key_level;
   logic            key_pulse;
   logic [CNTW-1:0] press_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   key_press_pulser #(
      .KEY_CODE        (8'h28),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (CNTW)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .en          (en),
      .key_level   (key_level),
      .key_pulse   (key_pulse),
      .press_count (press_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Runs n cycles, checking key_pulse (high only in cycle pulse_at) and
   // key_level (high for rise <= cycle < fall).
   task automatic window(input string tag, input int n, input int pulse_at,
                         input int rise, input int fall);
      for (int k = 1; k <= n; k++) begin
         tick();
         check($sformatf("%s pulse c%0d", tag, k), 32'(key_pulse), 32'(k == pulse_at));
         check($sformatf("%s level c%0d", tag, k), 32'(key_level),
               32'((k >= rise) && (k < fall)));
      end
   endtask

   task automatic check_count(input string tag, input int exp);
      check(tag, 32'(press_count), 32'(exp));
   endtask

   // One clean press/release; returns how many pulses were seen.
   task automatic press_release(output int pulses);
      pulses  = 0;
      keycode = 32'h0000_0028;
      repeat (DEB + 3) begin
         tick();
         if (key_pulse) pulses++;
      end
      keycode = 32'h0000_0000;
      repeat (DEB + 3) begin
         tick();
         if (key_pulse) pulses++;
      end
   endtask

   initial begin
      int p;
      int total;

      // ---- Reset state ------------------------------------------------------
      Reset   = 1'b1;
      en      = 1'b1;
      keycode = 32'h0;
      tick();
      tick();
      check("rst pulse", 32'(key_pulse), 32'd0);
      check("rst level", 32'(key_level), 32'd0);
      check_count("rst count", 0);
      Reset = 1'b0;
      window("idle", 3, NEVER, NEVER, NEVER);

      // ---- Short press (3 cycles) is a bounce -------------------------------
      keycode = 32'h0000_0028;
      window("bounce_on", 3, NEVER, NEVER, NEVER);
      keycode = 32'h0;
      window("bounce_off", 8, NEVER, NEVER, NEVER);
      check_count("bounce count", 0);

      // ---- Clean press held 20 cycles ----------------------------------------
      keycode = 32'h0000_0028;
      window("press", 20, DEB + 2, DEB + 2, NEVER);
      check_count("press count", 1);

      // ---- Release bounce: 2 cycles of 0 while held --------------------------
      keycode = 32'h0;
      window("rel_bounce0", 2, NEVER, 0, NEVER);
      keycode = 32'h0000_0028;
      window("rel_bounce1", 10, NEVER, 0, NEVER);
      check_count("rel_bounce count", 1);

      // ---- Real release: level falls at DEB+2 --------------------------------
      keycode = 32'h0;
      window("release", 10, NEVER, 0, DEB + 2);

      // ---- Key in two slots -> exactly one pulse -----------------------------
      keycode = 32'h2800_2800;
      window("two_slot", 20, DEB + 2, DEB + 2, NEVER);
      check_count("two_slot count", 2);
      keycode = 32'h0;
      window("two_slot_rel", 10, NEVER, 0, DEB + 2);

      // ---- Other key (Space) -> nothing ---------------------------------------
      keycode = 32'h0000_002C;
      window("space", 12, NEVER, NEVER, NEVER);
      check_count("space count", 2);
      keycode = 32'h0;
      tick();

      // ---- en=0: level tracks, no pulse, count frozen -------------------------
      en      = 1'b0;
      keycode = 32'hAA28_0000;
      window("en0", 12, NEVER, DEB + 2, NEVER);
      check_count("en0 count", 2);
      keycode = 32'h0;
      window("en0_rel", 10, NEVER, 0, DEB + 2);
      en = 1'b1;

      // ---- Reset mid-debounce with key held ------------------------------------
      keycode = 32'h0000_0028;
      window("pre_rst", 3, NEVER, NEVER, NEVER);
      Reset = 1'b1;
      tick();
      check("mid_rst pulse", 32'(key_pulse), 32'd0);
      check("mid_rst level", 32'(key_level), 32'd0);
      check_count("mid_rst count", 0);
      Reset = 1'b0;
      window("post_rst", 12, DEB + 2, DEB + 2, NEVER);
      check_count("post_rst count", 1);
      keycode = 32'h0;
      window("post_rst_rel", 10, NEVER, 0, DEB + 2);

      // ---- Reset while PRESSED clears level and count ---------------------------
      keycode = 32'h0000_0028;
      window("held", 8, DEB + 2, DEB + 2, NEVER);
      Reset = 1'b1;
      tick();
      check("held_rst level", 32'(key_level), 32'd0);
      check_count("held_rst count", 0);
      keycode = 32'h0;
      Reset   = 1'b0;
      window("held_rst_idle", 6, NEVER, NEVER, NEVER);

      // ---- 256 presses: counter wraps to 0 -------------------------------------
      total = 0;
      for (int i = 1; i <= 256; i++) begin
         press_release(p);
         total += p;
         if (i == 255) check_count("wrap count 255", 255);
      end
      check("wrap pulses", 32'(total), 32'd256);
      check_count("wrap count 0", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_key_press_pulser
